rect_fill_writer: RTL



---
 rtl/rect_fill_writer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rect_fill_writer.sv
// Rectangle-fill write engine: accepts one fill command, then streams one palette
// write per cycle over the rectangle in raster order, honouring write-port stalls.
module rect_fill_writer #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [$clog2(RESOLUTION_X)-1:0]   cmd_x0,
  input  logic [$clog2(RESOLUTION_Y)-1:0]   cmd_y0,
  input  logic [$clog2(RESOLUTION_X)-1:0]   cmd_x1,
  input  logic [$clog2(RESOLUTION_Y)-1:0]   cmd_y1,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] cmd_color,
  input  logic                              stall,
  output logic                              we,
  output logic [$clog2(RESOLUTION_X)-1:0]   wr_pxl_x,
  output logic [$clog2(RESOLUTION_Y)-1:0]   wr_pxl_y,
  output logic [$clog2(PALETTE_LENGTH)-1:0] wr_palette_index,
  output logic                              busy,
  output logic                              done
);

  localparam int XW = $clog2(RESOLUTION_X);
  localparam int YW = $clog2(RESOLUTION_Y);

  localparam logic [XW-1:0] X_LAST = XW'(RESOLUTION_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(RESOLUTION_Y - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state, state_next;

  // Only the bounds still needed after accept are kept; y_lo lives in wr_pxl_y.
  logic [XW-1:0] x_lo, x_hi;
  logic [YW-1:0] y_hi;

  logic [XW-1:0] acc_x_lo, acc_x_hi;
  logic [YW-1:0] acc_y_lo, acc_y_hi;
  logic          accept;
  logic          last_pxl;

  // Normalise the incoming corners and clip them to the visible area.
  always_comb begin
    acc_x_lo = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    acc_x_hi = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    acc_y_lo = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    acc_y_hi = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
    if (acc_x_lo > X_LAST) acc_x_lo = X_LAST;
    if (acc_x_hi > X_LAST) acc_x_hi = X_LAST;
    if (acc_y_lo > Y_LAST) acc_y_lo = Y_LAST;
    if (acc_y_hi > Y_LAST) acc_y_hi = Y_LAST;
  end

  assign accept   = cmd_valid && cmd_ready;
  assign last_pxl = (wr_pxl_x == x_hi) && (wr_pxl_y == y_hi);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    we         = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = FILL;
      end
      FILL: begin
        busy = 1'b1;
        we   = !stall;
        if (!stall && last_pxl) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_pxl_x         <= '0;
      wr_pxl_y         <= '0;
      wr_palette_index <= '0;
      x_lo             <= '0;
      x_hi             <= '0;
      y_hi             <= '0;
      done             <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        wr_pxl_x         <= acc_x_lo;
        wr_pxl_y         <= acc_y_lo;
        wr_palette_index <= cmd_color;
        x_lo             <= acc_x_lo;
        x_hi             <= acc_x_hi;
        y_hi             <= acc_y_hi;
      end else if (we) begin
        // The final pixel leaves the counters parked on (x_hi, y_hi).
        if (last_pxl) begin
          done <= 1'b1;
        end else if (wr_pxl_x < x_hi) begin
          wr_pxl_x <= wr_pxl_x + XW'(1);
        end else begin
          wr_pxl_x <= x_lo;
          wr_pxl_y <= wr_pxl_y + YW'(1);
        end
      end
    end
  end

endmodule
